rcv_controller: RTL and testbench

Receive control unit for the USB full-speed receiver. It sequences the NRZI `decode` / shift-register datapath:
- detects packet start;
- validates the sync byte;
- frames each received byte and issues one FIFO write per byte;
- recognises EOP and flags framing errors.

It sits between the edge detector / decoder / EOP detector and the receive FIFO.

---
 rtl/rcv_pkg.sv | 27 ++
 rtl/rcv_controller_if.sv | 31 +++
 rtl/rcv_bit_counter.sv | 44 ++++
 rtl/rcv_controller.sv | 126 ++++++++++++
 tb/tb_rcv_controller.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rcv_pkg.sv
// Package for the USB full-speed receive controller.
// Holds the controller state encoding and the default parameter values
// shared by the controller, its bit counter and any bench that drives it.
package rcv_pkg;

    // Sync pattern expected after the first eight bits of a packet.
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h80;

    // Maximum data bytes per packet before an overflow error.
    localparam int DEFAULT_MAX_BYTES = 64;

    // Bits in a received byte; the bit counter saturates here.
    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

    typedef enum logic [3:0] {
        IDLE,
        RCV_SYNC,
        SYNC_CHK,
        RCV_DATA,
        STORE,
        EOP_END,
        ERR_WAIT,
        ERR_EOP,
        EIDLE
    } rcv_state_t;

endpackage

// File: rtl/rcv_controller_if.sv
// Handshake bundle between the receive datapath (edge detector, NRZI
// decoder, EOP detector, shift register) and the receive controller.
//   d_edge       : one-cycle pulse on any d_plus transition
//   eop          : SE0 currently detected
//   shift_enable : one-cycle pulse at each bit sample point
//   rcv_data     : parallel shift register contents, LSB first
//   rcving       : packet reception in progress
//   w_enable     : one-cycle FIFO write strobe per stored byte
//   r_error      : sticky receive error flag
// The datapath side uses the master modport, the controller the slave.
interface rcv_controller_if;

    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;

    modport master (
        output d_edge, eop, shift_enable, rcv_data,
        input  rcving, w_enable, r_error
    );

    modport slave (
        input  d_edge, eop, shift_enable, rcv_data,
        output rcving, w_enable, r_error
    );

endinterface

// File: rtl/rcv_bit_counter.sv
// Bit counter for the receive controller.
// Counts shift_enable pulses from 0 up to 8 and saturates there.
//   clk, rst  : clock and asynchronous active-high reset
//   clear     : return the count to 0 (wins over counting)
//   count_en  : advance by one bit
//   bit_cnt   : current count, 0..8
//   rollover  : high in the cycle whose count_en completes the 8th bit
module rcv_bit_counter
    import rcv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       count_en,
    output logic [3:0] bit_cnt,
    output logic       rollover
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 4'd0;
        end else if (count_en && (cnt_q != BITS_PER_BYTE)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Rollover is flagged while the 8th pulse is present rather than once the
    // count shows 8, so the FSM can leave on the same edge that samples it.
    assign rollover = count_en && (cnt_q == (BITS_PER_BYTE - 4'd1));
    assign bit_cnt  = cnt_q;

endmodule

// File: rtl/rcv_controller.sv
// Receive control unit for the USB full-speed receiver.
// Detects packet start, checks the sync byte, frames data bytes into one
// FIFO write each, recognises EOP and flags framing/overflow errors.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : datapath handshake (slave side), see rcv_controller_if
// Parameters: SYNC_BYTE (expected sync pattern), MAX_BYTES (bytes per packet).
module rcv_controller
    import rcv_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         MAX_BYTES = DEFAULT_MAX_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    rcv_controller_if.slave  bus
);

    // One byte beyond the limit is the overflow point, and also where the
    // byte counter saturates.
    localparam logic [6:0] BYTE_LIMIT = 7'(MAX_BYTES + 1);

    rcv_state_t state_q, state_d;
    logic [6:0] byte_cnt_q, byte_cnt_d;
    logic [6:0] byte_cnt_inc;
    logic       bit_clear;
    logic [3:0] bit_cnt;
    logic       rollover;
    logic       eop_sample;

    rcv_bit_counter u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (bit_clear),
        .count_en (bus.shift_enable),
        .bit_cnt  (bit_cnt),
        .rollover (rollover)
    );

    assign eop_sample   = bus.eop && bus.shift_enable;
    assign byte_cnt_inc = (byte_cnt_q == BYTE_LIMIT) ? byte_cnt_q : byte_cnt_q + 7'd1;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_clear  = 1'b0;
        case (state_q)
            IDLE, EIDLE: begin
                if (bus.d_edge) begin
                    state_d    = RCV_SYNC;
                    bit_clear  = 1'b1;
                    byte_cnt_d = 7'd0;
                end
            end
            RCV_SYNC: begin
                if (eop_sample) begin
                    state_d = ERR_EOP;
                end else if (rollover) begin
                    state_d = SYNC_CHK;
                end
            end
            SYNC_CHK: begin
                bit_clear = 1'b1;
                state_d   = (bus.rcv_data == SYNC_BYTE) ? RCV_DATA : ERR_WAIT;
            end
            RCV_DATA: begin
                // EOP wins over a byte completing on the same sample.
                if (eop_sample) begin
                    state_d = (bit_cnt == 4'd0) ? EOP_END : ERR_EOP;
                end else if (rollover) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                bit_clear  = 1'b1;
                byte_cnt_d = byte_cnt_inc;
                state_d    = (byte_cnt_inc == BYTE_LIMIT) ? ERR_WAIT : RCV_DATA;
            end
            EOP_END: begin
                if (bus.d_edge) begin
                    state_d = IDLE;
                end
            end
            ERR_WAIT: begin
                if (eop_sample) begin
                    state_d = ERR_EOP;
                end
            end
            ERR_EOP: begin
                if (bus.d_edge) begin
                    state_d = EIDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= 7'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        bus.rcving   = 1'b1;
        bus.w_enable = 1'b0;
        bus.r_error  = 1'b0;
        case (state_q)
            IDLE:              bus.rcving  = 1'b0;
            STORE:             bus.w_enable = 1'b1;
            ERR_WAIT, ERR_EOP: bus.r_error = 1'b1;
            EIDLE: begin
                bus.rcving  = 1'b0;
                bus.r_error = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rcv_controller.sv
// Self-checking bench for rcv_controller (MAX_BYTES = 2, SYNC_BYTE = 8'h80).
// A table of per-cycle vectors {d_edge, eop, shift_enable, rcv_data,
// expected rcving/w_enable/r_error} is built from short packet recipes,
// the expected triple is queued as each vector is driven and popped when
// the outputs are sampled one time unit after the clock edge.
module tb_rcv_controller;

    localparam int TB_MAX_BYTES = 2;

    logic clk;
    logic rst;

    rcv_controller_if bus ();

    rcv_controller #(
        .SYNC_BYTE (8'h80),
        .MAX_BYTES (TB_MAX_BYTES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       de;
        logic       eo;
        logic       se;
        logic [7:0] data;
        logic [2:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] expQ[$];
    logic [7:0] sr;
    int         errors = 0;
    int         checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not end, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // One cycle of stimulus with the outputs expected after the next edge.
    task automatic addVec(input logic de, input logic eo, input logic se,
                          input logic [7:0] data,
                          input logic r, input logic w, input logic e);
        vec_t v;
        v.de   = de;
        v.eo   = eo;
        v.se   = se;
        v.data = data;
        v.exp  = {r, w, e};
        vecs.push_back(v);
    endtask

    // n bits of byte b, LSB first, two cycles per bit. The shift register
    // model moves on the shift_enable edge; d_edge pulses on zero bits
    // mimic NRZI transitions that the controller must ignore mid-packet.
    task automatic addBits(input logic [7:0] b, input int n,
                           input logic r, input logic e,
                           input logic wLast, input logic eAfter);
        for (int i = 0; i < n; i++) begin
            addVec(1'b0, 1'b0, 1'b1, sr, r, (i == n - 1) ? wLast : 1'b0, e);
            sr = {b[i], sr[7:1]};
            addVec(~b[i], 1'b0, 1'b0, sr, r, 1'b0, (i == n - 1) ? eAfter : e);
        end
    endtask

    task automatic compare(input string name, input logic [2:0] exp);
        logic [2:0] act;
        act = {bus.rcving, bus.w_enable, bus.r_error};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: rcving/w_enable/r_error got %b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        expQ.push_back(v.exp);
        bus.d_edge       = v.de;
        bus.eop          = v.eo;
        bus.shift_enable = v.se;
        bus.rcv_data     = v.data;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int idx);
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: got no expectation expected one at vec%0d", idx);
        end else begin
            compare($sformatf("vec%0d", idx), expQ.pop_front());
        end
    endtask

    task automatic runTable();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end
        vecs.delete();
        bus.d_edge       = 1'b0;
        bus.eop          = 1'b0;
        bus.shift_enable = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.d_edge       = 1'b0;
        bus.eop          = 1'b0;
        bus.shift_enable = 1'b0;
        bus.rcv_data     = 8'h00;
        sr               = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_state", 3'b000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        compare("after_reset", 3'b000);

        // Idle: shift pulses alone do nothing.
        addVec(1'b0, 1'b0, 1'b1, sr, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 1'b0, sr, 1'b0, 1'b0, 1'b0);

        // Valid packet: sync, A5, 3C, clean EOP, return to J.
        addVec(1'b1, 1'b0, 1'b0, sr, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 1'b0, sr, 1'b1, 1'b0, 1'b0);
        addBits(8'h80, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        addBits(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        addBits(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 1'b1, 1'b1, sr, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 1'b0, sr, 1'b1, 1'b0, 1'b0);
        addVec(1'b1, 1'b0, 1'b0, sr, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 1'b0, sr, 1'b0, 1'b0, 1'b0);

        // Bad sync 81: error, no writes, EIDLE keeps the flag, next edge clears it.
        addVec(1'b1, 1'b0, 1'b0, sr, 1'b1, 1'b0, 1'b0);
        addBits(8'h81, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        addBits(8'hA5, 8, 1'b1, 1'b1, 1'b0, 1'b1);
        addVec(1'b0, 1'b1, 1'b1, sr, 1'b1, 1'b0, 1'b1);
        addVec(1'b0, 1'b1, 1'b0, sr, 1'b1, 1'b0, 1'b1);
        addVec(1'b1, 1'b0, 1'b0, sr, 1'b0, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 1'b0, sr, 1'b0, 1'b0, 1'b1);
        addVec(1'b1, 1'b0, 1'b0, sr, 1'b1, 1'b0, 1'b0);

        // Early EOP after three data bits.
        addBits(8'h80, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        addBits(8'h5A, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 1'b1, sr, 1'b1, 1'b0, 1'b1);
        addVec(1'b0, 1'b1, 1'b0, sr, 1'b1, 1'b0, 1'b1);
        addVec(1'b1, 1'b0, 1'b0, sr, 1'b0, 1'b0, 1'b1);
        addVec(1'b1, 1'b0, 1'b0, sr, 1'b1, 1'b0, 1'b0);

        // Overflow: third byte still written, fourth ignored.
        addBits(8'h80, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        addBits(8'h11, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        addBits(8'h22, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        addBits(8'h33, 8, 1'b1, 1'b0, 1'b1, 1'b1);
        addBits(8'h44, 8, 1'b1, 1'b1, 1'b0, 1'b1);
        addVec(1'b0, 1'b1, 1'b1, sr, 1'b1, 1'b0, 1'b1);
        addVec(1'b1, 1'b0, 1'b0, sr, 1'b0, 1'b0, 1'b1);
        addVec(1'b1, 1'b0, 1'b0, sr, 1'b1, 1'b0, 1'b0);

        // EOP together with the 8th data bit: error, no write.
        addBits(8'h80, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        addBits(8'hC3, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 1'b1, sr, 1'b1, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 1'b0, sr, 1'b1, 1'b0, 1'b1);
        addVec(1'b1, 1'b0, 1'b0, sr, 1'b0, 1'b0, 1'b1);
        addVec(1'b1, 1'b0, 1'b0, sr, 1'b1, 1'b0, 1'b0);

        // Into RCV_DATA with a partial byte, ready for the reset test.
        addBits(8'h80, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        addBits(8'hFF, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        runTable();

        // Asynchronous reset in the middle of a byte.
        compare("pre_reset", 3'b100);
        #2;
        rst = 1'b1;
        #1;
        compare("async_reset", 3'b000);
        @(posedge clk);
        #1;
        compare("reset_held", 3'b000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        compare("reset_release", 3'b000);

        // After reset the controller is idle and receives a fresh packet.
        sr = 8'h00;
        addVec(1'b0, 1'b0, 1'b1, sr, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 1'b0, sr, 1'b0, 1'b0, 1'b0);
        addVec(1'b1, 1'b0, 1'b0, sr, 1'b1, 1'b0, 1'b0);
        addBits(8'h80, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        addBits(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 1'b1, 1'b1, sr, 1'b1, 1'b0, 1'b0);
        addVec(1'b1, 1'b0, 1'b0, sr, 1'b0, 1'b0, 1'b0);
        runTable();

        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover: got %0d pending expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
